// File: rtl/brickbreaker_pkg.sv
// Shared screen geometry, colour constants and redraw state encoding for the
// brick-breaker video path.
package brickbreaker_pkg;

  // Visible raster size; pixel sums are 9 bits (x) and 8 bits (y) wide
  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [7:0] SCREEN_H = 8'd120;

  // Default colours (3-bit RGB)
  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_CYAN  = 3'b011;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  // Redraw sequencer states. Each rectangle state names the rectangle whose
  // pixel is currently presented on the write port.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LATCH      = 3'd1,
    ST_ERASE_BALL = 3'd2,
    ST_DRAW_BALL  = 3'd3,
    ST_ERASE_PAD  = 3'd4,
    ST_DRAW_PAD   = 3'd5,
    ST_FINISH     = 3'd6
  } state_t;

  // Successor of a state in the redraw order; erase states are skipped when
  // nothing has been drawn yet.
  function automatic state_t next_rect_state(input state_t s, input logic valid);
    state_t n;
    n = ST_IDLE;
    case (s)
      ST_LATCH: begin
        if (valid) n = ST_ERASE_BALL;
        else       n = ST_DRAW_BALL;
      end
      ST_ERASE_BALL: n = ST_DRAW_BALL;
      ST_DRAW_BALL: begin
        if (valid) n = ST_ERASE_PAD;
        else       n = ST_DRAW_PAD;
      end
      ST_ERASE_PAD: n = ST_DRAW_PAD;
      ST_DRAW_PAD:  n = ST_FINISH;
      default:      n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rect_scan.sv
// Row-major rectangle offset generator. The offset on col/row is the one being
// issued this cycle: a start pulse issues (0,0) in the same cycle, after which
// the counters step one pixel per cycle until the last pixel has been issued.
module rect_scan (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] col,
  output logic [6:0] row,
  output logic       active,
  output logic       last
);

  logic [7:0] col_reg;
  logic [6:0] row_reg;
  logic       run_reg;

  assign active = start | run_reg;
  assign col    = start ? 8'd0 : col_reg;
  assign row    = start ? 7'd0 : row_reg;
  assign last   = active && (col == width - 8'd1) && (row == height - 7'd1);

  // Advance the column counter, wrapping into the next row at the right edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_reg <= 8'd0;
      row_reg <= 7'd0;
      run_reg <= 1'b0;
    end else if (active) begin
      if (last) begin
        col_reg <= 8'd0;
        row_reg <= 7'd0;
        run_reg <= 1'b0;
      end else if (col == width - 8'd1) begin
        col_reg <= 8'd0;
        row_reg <= row + 7'd1;
        run_reg <= 1'b1;
      end else begin
        col_reg <= col + 8'd1;
        row_reg <= row;
        run_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_scheduler.sv
// Frame redraw sequencer: on each frame tick it erases the ball and paddle at
// their previous positions and redraws them at freshly latched positions,
// emitting one registered pixel write per cycle with screen-edge clipping.
module plot_scheduler
  import brickbreaker_pkg::*;
#(
  parameter int         BALL_SIZE   = 2,
  parameter int         PAD_W       = 16,
  parameter int         PAD_H       = 2,
  parameter logic [2:0] BALL_COLOUR = COLOUR_WHITE,
  parameter logic [2:0] PAD_COLOUR  = COLOUR_CYAN,
  parameter logic [2:0] BG_COLOUR   = COLOUR_BLACK
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic [7:0] pad_x,
  input  logic [6:0] pad_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam logic [7:0] BALL_W8 = 8'(BALL_SIZE);
  localparam logic [6:0] BALL_H7 = 7'(BALL_SIZE);
  localparam logic [7:0] PAD_W8  = 8'(PAD_W);
  localparam logic [6:0] PAD_H7  = 7'(PAD_H);

  state_t state;

  // Positions drawn last frame (erase targets) and latched for this frame
  logic [7:0] ball_prev_x_reg, pad_prev_x_reg, ball_new_x_reg, pad_new_x_reg;
  logic [6:0] ball_prev_y_reg, pad_prev_y_reg, ball_new_y_reg, pad_new_y_reg;
  logic       drawn_valid_reg;

  // High while the final pixel of the current rectangle is being presented
  logic       last_shown_reg;

  // Scanner interface and issue-side pixel
  logic       scan_start, scan_active, scan_last;
  logic [7:0] scan_col, scan_w;
  logic [6:0] scan_row, scan_h;
  state_t     follow, issue_kind;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] issue_colour;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic       in_bounds;
  logic       in_rect_state;

  assign in_rect_state = (state == ST_ERASE_BALL) || (state == ST_DRAW_BALL) ||
                         (state == ST_ERASE_PAD)  || (state == ST_DRAW_PAD);

  // Pick the rectangle whose pixel is issued this cycle. The scanner runs one
  // cycle ahead of the output registers, so the first pixel of a rectangle is
  // issued while the previous state (LATCH or the prior rectangle's final
  // pixel) is still presented.
  always_comb begin
    follow       = next_rect_state(state, drawn_valid_reg);
    scan_start   = (state == ST_LATCH) ||
                   (in_rect_state && last_shown_reg && (follow != ST_FINISH));
    issue_kind   = scan_start ? follow : state;
    base_x       = 8'd0;
    base_y       = 7'd0;
    scan_w       = 8'd1;
    scan_h       = 7'd1;
    issue_colour = BG_COLOUR;
    case (issue_kind)
      ST_ERASE_BALL: begin
        base_x = ball_prev_x_reg;
        base_y = ball_prev_y_reg;
        scan_w = BALL_W8;
        scan_h = BALL_H7;
      end
      ST_DRAW_BALL: begin
        // During LATCH the new-position registers are only being loaded, so
        // the very first ball pixel comes straight from the inputs.
        base_x       = (state == ST_LATCH) ? ball_x : ball_new_x_reg;
        base_y       = (state == ST_LATCH) ? ball_y : ball_new_y_reg;
        scan_w       = BALL_W8;
        scan_h       = BALL_H7;
        issue_colour = BALL_COLOUR;
      end
      ST_ERASE_PAD: begin
        base_x = pad_prev_x_reg;
        base_y = pad_prev_y_reg;
        scan_w = PAD_W8;
        scan_h = PAD_H7;
      end
      ST_DRAW_PAD: begin
        base_x       = pad_new_x_reg;
        base_y       = pad_new_y_reg;
        scan_w       = PAD_W8;
        scan_h       = PAD_H7;
        issue_colour = PAD_COLOUR;
      end
      default: begin
        base_x = 8'd0;
      end
    endcase
  end

  // Widened sums so that off-screen pixels clip instead of wrapping
  assign pix_x     = {1'b0, base_x} + {1'b0, scan_col};
  assign pix_y     = {1'b0, base_y} + {1'b0, scan_row};
  assign in_bounds = (pix_x < SCREEN_W) && (pix_y < SCREEN_H);

  rect_scan u_scan (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .width  (scan_w),
    .height (scan_h),
    .col    (scan_col),
    .row    (scan_row),
    .active (scan_active),
    .last   (scan_last)
  );

  // Sequencer: state transitions, position bookkeeping and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      x               <= 8'd0;
      y               <= 7'd0;
      colour          <= 3'd0;
      writeEn         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
      last_shown_reg  <= 1'b0;
      drawn_valid_reg <= 1'b0;
      ball_prev_x_reg <= 8'd0;
      ball_prev_y_reg <= 7'd0;
      pad_prev_x_reg  <= 8'd0;
      pad_prev_y_reg  <= 7'd0;
      ball_new_x_reg  <= 8'd0;
      ball_new_y_reg  <= 7'd0;
      pad_new_x_reg   <= 8'd0;
      pad_new_y_reg   <= 7'd0;
    end else begin
      done           <= 1'b0;
      writeEn        <= 1'b0;
      overrun        <= frame_tick && busy;
      last_shown_reg <= scan_last;

      // Present the issued pixel; clipped pixels leave x/y/colour untouched
      if (scan_active) begin
        writeEn <= in_bounds;
        if (in_bounds) begin
          x      <= pix_x[7:0];
          y      <= pix_y[6:0];
          colour <= issue_colour;
        end
      end

      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state <= ST_LATCH;
            busy  <= 1'b1;
          end
        end
        ST_LATCH: begin
          ball_new_x_reg <= ball_x;
          ball_new_y_reg <= ball_y;
          pad_new_x_reg  <= pad_x;
          pad_new_y_reg  <= pad_y;
          state          <= follow;
        end
        ST_ERASE_BALL, ST_DRAW_BALL, ST_ERASE_PAD, ST_DRAW_PAD: begin
          if (last_shown_reg) begin
            state <= follow;
            if (follow == ST_FINISH) done <= 1'b1;
          end
        end
        ST_FINISH: begin
          ball_prev_x_reg <= ball_new_x_reg;
          ball_prev_y_reg <= ball_new_y_reg;
          pad_prev_x_reg  <= pad_new_x_reg;
          pad_prev_y_reg  <= pad_new_y_reg;
          drawn_valid_reg <= 1'b1;
          busy            <= 1'b0;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// Self-checking bench for plot_scheduler: a table of frames with expected busy
// length and write counts, a pixel scoreboard filled from a small reference
// model, and in-frame corner cases (overrun, input change, mid-frame reset).
module tb_plot_scheduler;

  logic       clk;
  logic       resetn;
  logic       frame_tick;
  logic [7:0] ball_x, pad_x;
  logic [6:0] ball_y, pad_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       writeEn, busy, done, overrun;

  plot_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pad_x      (pad_x),
    .pad_y      (pad_y),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .writeEn    (writeEn),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  // inject: 0 none, 1 second tick at cycle 5, 2 inputs change mid-draw,
  //         3 reset during DRAW_PAD
  typedef struct {
    logic [7:0] bx;
    logic [6:0] by;
    logic [7:0] px;
    logic [6:0] py;
    int         inject;
    int         exp_busy;
    int         exp_writes;
  } vec_t;

  pix_t exp_q[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   wr_count = 0;

  // Reference model state: what the design should have on screen
  bit         m_valid = 0;
  logic [7:0] m_bx, m_px;
  logic [6:0] m_by, m_py;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_rect(input int bx, input int by, input int w, input int h,
                           input logic [2:0] c);
    pix_t p;
    for (int r = 0; r < h; r++) begin
      for (int cc = 0; cc < w; cc++) begin
        int xx, yy;
        xx = bx + cc;
        yy = by + r;
        if (xx < 160 && yy < 120) begin
          p.x = 8'(xx);
          p.y = 7'(yy);
          p.c = c;
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic push_frame(input vec_t v);
    if (m_valid) push_rect(int'(m_bx), int'(m_by), 2, 2, 3'b000);
    push_rect(int'(v.bx), int'(v.by), 2, 2, 3'b111);
    if (m_valid) push_rect(int'(m_px), int'(m_py), 16, 2, 3'b000);
    push_rect(int'(v.px), int'(v.py), 16, 2, 3'b011);
    m_bx = v.bx; m_by = v.by; m_px = v.px; m_py = v.py;
    m_valid = 1;
  endtask

  // Scoreboard consumer: every write must match the next expected pixel
  always @(negedge clk) begin
    if (resetn && writeEn) begin
      pix_t e;
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected actual=(%0d,%0d,c%0d) required=none", x, y, colour);
      end else begin
        e = exp_q.pop_front();
        if (x !== e.x || y !== e.y || colour !== e.c) begin
          failures++;
          $display("FAIL pixel actual=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
                   x, y, colour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic run_frame(input int idx);
    vec_t v;
    int   cyc, busy_cnt, done_cyc, done_cnt, ov_cnt;
    bit   aborted, restarted;
    v = vecs[idx];
    push_frame(v);
    wr_count = 0;
    aborted  = 0;
    @(posedge clk); #1;
    ball_x = v.bx; ball_y = v.by; pad_x = v.px; pad_y = v.py;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    cyc = 1; busy_cnt = 1; done_cnt = 0; done_cyc = -1; ov_cnt = 0;
    chk($sformatf("f%0d_latch_busy", idx), int'(busy), 1);
    chk($sformatf("f%0d_latch_wen", idx), int'(writeEn), 0);
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) chk($sformatf("f%0d_first_pixel_wen", idx), int'(writeEn), 1);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (overrun) ov_cnt++;
      if (v.inject == 1 && cyc == 5) frame_tick = 1'b1;
      if (v.inject == 1 && cyc == 6) frame_tick = 1'b0;
      if (v.inject == 2 && cyc == 7) begin
        ball_x = v.bx + 8'd50; ball_y = v.by + 7'd9;
        pad_x  = v.px + 8'd3;  pad_y  = v.py - 7'd5;
      end
      if (v.inject == 3 && cyc == 50) begin
        chk("pre_reset_wen", int'(writeEn), 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_wen", int'(writeEn), 0);
        chk("async_reset_busy", int'(busy), 0);
        exp_q.delete();
        m_valid = 0;
        aborted = 1;
        break;
      end
      if (!busy) break;
      busy_cnt++;
    end
    if (aborted) begin
      repeat (2) @(posedge clk);
      #1;
      chk("in_reset_x", int'(x), 0);
      chk("in_reset_done", int'(done), 0);
      resetn = 1'b1;
      $display("frame %0d aborted by reset at cycle %0d", idx, cyc);
    end else begin
      if (cyc >= 300) chk($sformatf("f%0d_timeout", idx), 1, 0);
      chk($sformatf("f%0d_busy_cycles", idx), busy_cnt, v.exp_busy);
      chk($sformatf("f%0d_done_cycle", idx), done_cyc, v.exp_busy);
      chk($sformatf("f%0d_done_pulses", idx), done_cnt, 1);
      chk($sformatf("f%0d_writes", idx), wr_count, v.exp_writes);
      chk($sformatf("f%0d_queue_left", idx), exp_q.size(), 0);
      chk($sformatf("f%0d_overrun", idx), ov_cnt, (v.inject == 1) ? 1 : 0);
      if (v.inject == 1) begin
        restarted = 0;
        repeat (10) begin
          @(posedge clk); #1;
          if (busy || writeEn) restarted = 1;
        end
        chk("no_second_sequence", int'(restarted), 0);
      end
      $display("frame %0d ball=(%0d,%0d) pad=(%0d,%0d) busy=%0d writes=%0d",
               idx, v.bx, v.by, v.px, v.py, busy_cnt, wr_count);
    end
  endtask

  initial begin
    vecs[0] = '{8'd10,  7'd20,  8'd72,  7'd110, 0, 38, 36};
    vecs[1] = '{8'd12,  7'd22,  8'd72,  7'd110, 0, 74, 72};
    vecs[2] = '{8'd40,  7'd50,  8'd150, 7'd119, 0, 74, 50};
    vecs[3] = '{8'd158, 7'd118, 8'd0,   7'd0,   0, 74, 50};
    vecs[4] = '{8'd159, 7'd119, 8'd144, 7'd118, 0, 74, 69};
    vecs[5] = '{8'd60,  7'd60,  8'd72,  7'd100, 1, 74, 69};
    vecs[6] = '{8'd30,  7'd40,  8'd20,  7'd90,  2, 74, 72};
    vecs[7] = '{8'd80,  7'd80,  8'd60,  7'd100, 3, 0,  0};
    vecs[8] = '{8'd5,   7'd6,   8'd100, 7'd50,  0, 38, 36};
    vecs[9] = '{8'd5,   7'd6,   8'd100, 7'd50,  0, 74, 72};

    resetn = 1'b0; frame_tick = 1'b0;
    ball_x = 8'd0; ball_y = 7'd0; pad_x = 8'd0; pad_y = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_wen", int'(writeEn), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_overrun", int'(overrun), 0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 10; i++) run_frame(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plot_scheduler.md
PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 Parameter BALL_SIZE, default 2: ball side length in pixels (square).
REQ-002 Parameter PAD_W, default 16: paddle width in pixels.
REQ-003 Parameter PAD_H, default 2: paddle height in pixels.
REQ-004 Parameter BALL_COLOUR, default 3'b111: ball colour.
REQ-005 Parameter PAD_COLOUR, default 3'b011: paddle colour.
REQ-006 Parameter BG_COLOUR, default 3'b000: erase colour.
REQ-007 clk  in  1  system clock (CLOCK_50 domain); single clock, all logic on rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 frame_tick  in  1  one-cycle pulse from the delay counter requesting a redraw.
REQ-010 ball_x  in  8 / ball_y  in  7  current ball top-left position.
REQ-011 pad_x  in  8 / pad_y  in  7  current paddle top-left position.
REQ-012 x  out  8 / y  out  7 / colour  out  3 / writeEn  out  1  registered pixel-write port to the VGA adapter.
REQ-013 busy  out  1  high while a redraw sequence is in progress.
REQ-014 done  out  1  one-cycle pulse when a sequence completes.
REQ-015 overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Function
REQ-016 FSM states: IDLE, LATCH, ERASE_BALL, DRAW_BALL, ERASE_PAD, DRAW_PAD, FINISH.
REQ-017 IDLE -> LATCH on frame_tick; otherwise remain in IDLE.
REQ-018 LATCH: sample ball_x/y, pad_x/y into new-position registers; one cycle; busy high from this cycle.
REQ-019 Order after LATCH: ERASE_BALL, DRAW_BALL, ERASE_PAD, DRAW_PAD, FINISH, IDLE.
REQ-020 ERASE_* states use previous-frame positions and BG_COLOUR; DRAW_* use latched positions and object colour.
REQ-021 ERASE_* states are skipped (direct transition to next DRAW_*) when the drawn-valid flag is clear.
REQ-022 Each rectangle state scans row-major, column counter inner, one pixel per cycle; BALL states take BALL_SIZE^2 cycles, PAD states PAD_W*PAD_H cycles.
REQ-023 Pixel coordinate = base + offset computed 9 bits (x) / 8 bits (y); writeEn forced low for that cycle if x >= 160 or y >= 120 (clip, no wrap); scan still advances.
REQ-024 First writeEn high occurs 2 cycles after the frame_tick cycle (tick at T, LATCH at T+1, first pixel presented at T+2).
REQ-025 FINISH: copy latched positions into previous-position registers, set drawn-valid, pulse done, busy low next cycle.
REQ-026 Full sequence with valid flag set, defaults: 1 + 4 + 4 + 32 + 32 + 1 = 74 cycles from LATCH through FINISH.
REQ-027 frame_tick while busy (LATCH through FINISH) is dropped and pulses overrun the next cycle; no queuing.
REQ-028 Input position changes after LATCH have no effect on the current sequence.
REQ-029 writeEn low in IDLE, LATCH, FINISH; x, y, colour hold last value when writeEn low.

Reset
REQ-030 resetn low asynchronously forces state IDLE, writeEn/busy/done/overrun 0, x/y/colour 0, counters 0, position registers 0, drawn-valid clear.
REQ-031 Reset mid-sequence abandons the sequence; first sequence after reset performs no erase.

Structure
REQ-032 Shared package brickbreaker_pkg holds SCREEN_W=160, SCREEN_H=120, colour constants, and state encoding.
REQ-033 One sub-module rect_scan: start pulse, width/height, outputs col/row offsets, active, last; instantiated once and reused by all rectangle states.

Verification
REQ-034 Reset, tick with ball (10,20), pad (72,110) -> no erase; 4 writes (10..11,20..21) colour 7, then 32 paddle writes colour 3; done at cycle 38 after tick (1 LATCH + 36 pixels + FINISH).
REQ-035 Second tick with ball (12,22) -> 4 erase writes at (10..11,20..21) colour 0 before ball draw at (12..13,22..23); total 74 busy cycles.
REQ-036 Pad at (150,119), PAD_W 16, PAD_H 2 -> only pixels x 150..159, y 119 write (10 writeEn); scan still 32 cycles.
REQ-037 frame_tick pulsed 5 cycles into a sequence -> overrun pulse, sequence unchanged, no second sequence started.
REQ-038 resetn low during DRAW_PAD -> writeEn 0 immediately, busy 0; next tick draws without erase.
REQ-039 ball_x changed during DRAW_BALL -> drawn pixels match value latched at LATCH.
